// File: rtl/alu_seq.sv
// alu_seq: handshaked RV32I integer ALU with an iterative barrel shifter
module alu_seq #(
  parameter int WIDTH      = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] operand_1_i,
  input  logic [WIDTH-1:0] operand_2_i,
  input  logic [2:0]       funct3_i,
  input  logic [6:0]       funct7_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] result_o
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW:0] STEP = (CW+1)'(SHIFT_STEP);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d, alu, shifted;
  logic signed [WIDTH-1:0] sra_v;
  logic [CW-1:0] rem_q, rem_d, shamt;
  logic [CW:0] amt;
  logic left_q, left_d, arith_q, arith_d, accept, last, is_shift, unused_f7;
  assign unused_f7 = ^{funct7_i[6], funct7_i[4:0]};
  assign ready_o = (state_q == IDLE) || (state_q == DONE && ready_i);
  assign valid_o = (state_q == DONE);
  assign result_o = res_q;
  assign accept = valid_i && ready_o;
  assign shamt = operand_2_i[CW-1:0];
  assign is_shift = (funct3_i == 3'b001) || (funct3_i == 3'b101);
  // single-cycle result for the accepted op; a shift by zero passes operand_1 through
  always_comb begin
    alu = '0;
    case (funct3_i)
      3'b000: alu = funct7_i[5] ? operand_1_i + ~operand_2_i + WIDTH'(1) : operand_1_i + operand_2_i;
      3'b010: alu = WIDTH'($signed(operand_1_i) < $signed(operand_2_i));
      3'b011: alu = WIDTH'(operand_1_i < operand_2_i);
      3'b100: alu = operand_1_i ^ operand_2_i;
      3'b110: alu = operand_1_i | operand_2_i;
      3'b111: alu = operand_1_i & operand_2_i;
      default: alu = operand_1_i;
    endcase
  end
  // one shifter step of at most SHIFT_STEP bits; arithmetic shift keeps the original sign in the MSB
  always_comb begin
    last = {1'b0, rem_q} <= STEP;
    amt = last ? {1'b0, rem_q} : STEP;
    sra_v = $signed(res_q) >>> amt;
    shifted = left_q ? res_q << amt : arith_q ? sra_v : res_q >> amt;
  end
  // next-state: accept has priority, otherwise retire the result or advance the shift
  always_comb begin
    state_d = state_q;
    res_d = res_q;
    rem_d = rem_q;
    left_d = left_q;
    arith_d = arith_q;
    if (accept) begin
      state_d = (is_shift && shamt != '0) ? SHIFT : DONE;
      res_d = (is_shift && shamt != '0) ? operand_1_i : alu;
      rem_d = is_shift ? shamt : '0;
      left_d = funct3_i == 3'b001;
      arith_d = funct7_i[5];
    end else if (state_q == DONE && ready_i) begin
      state_d = IDLE;
    end else if (state_q == SHIFT) begin
      res_d = shifted;
      rem_d = rem_q - amt[CW-1:0];
      state_d = last ? DONE : SHIFT;
    end
  end
  // state and datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      res_q <= '0;
      rem_q <= '0;
      left_q <= 1'b0;
      arith_q <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q <= res_d;
      rem_q <= rem_d;
      left_q <= left_d;
      arith_q <= arith_d;
    end
  end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked integer ALU that implements the full RV32I register/immediate operation set: ADD/SUB, SLL, SLT, SLTU, XOR, SRL/SRA, OR and AND. It sits between the operand-read stage and write-back. Non-shift operations complete with one registered cycle of latency. Shifts run iteratively through an internal barrel step of SHIFT_STEP bits per cycle, trading latency for area. Valid/ready handshakes on both sides let the pipeline stall around multi-cycle shifts.

## Interface
- WIDTH, 32: operand/result width; power of two, ≥ 8.
- SHIFT_STEP, 1: maximum shift distance applied per cycle; power of two, 1..WIDTH.
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- valid_i  in  1  upstream operation valid.
- ready_o  out  1  block can accept an operation this cycle.
- operand_1_i  in  WIDTH  rs1 value.
- operand_2_i  in  WIDTH  rs2/immediate; shift amount = low log2(WIDTH) bits.
- funct3_i  in  3  RISC-V funct3 operation select.
- funct7_i  in  7  RISC-V funct7; only bit 5 used (SUB / SRA), others ignored.
- valid_o  out  1  result_o holds a completed result.
- ready_i  in  1  downstream accepts the result.
- result_o  out  WIDTH  registered result.

## Operation
- Accept: valid_i && ready_o at a rising edge; operands and function latched at that edge.
- FSM states:
  - IDLE → DONE on accept of a non-shift op, or a shift with shamt = 0.
  - IDLE → SHIFT on accept of a shift with shamt > 0.
  - SHIFT → DONE when the remaining shift amount ≤ SHIFT_STEP; the last step is applied on that edge.
  - DONE → IDLE on ready_i with no new accept.
  - DONE → DONE/SHIFT when ready_i and a new accept occur on the same edge.
- ready_o = (state == IDLE) || (state == DONE && ready_i). It is combinational from ready_i, with no path from valid_i.
- valid_o = (state == DONE).
- funct3 map:
  - 000: ADD, or SUB if funct7[5].
  - 001: SLL.
  - 010: SLT (signed).
  - 011: SLTU.
  - 100: XOR.
  - 101: SRL, or SRA if funct7[5].
  - 110: OR.
  - 111: AND.
- funct7[5] is ignored for funct3 other than 000/101.
- Arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH; no carry/overflow output.
  - SUB computes operand_1 + ~operand_2 + 1.
  - SLT/SLTU write 1 or 0 zero-extended to WIDTH.
- Shift datapath: the working register shifts by min(remaining, SHIFT_STEP) each SHIFT cycle. SRA fills with the original operand_1 MSB; SLL/SRL fill with zeros. Operand bits above the shamt field are ignored.
- result_o, valid_o and the latched operation stay stable in DONE until ready_i is high.
- A change on the input ports while not accepting has no effect.

## Timing
- Reset (rst_i high at an edge):
  - state = IDLE, valid_o = 0, result_o = 0, shift counter = 0.
  - ready_o = 1 from the next cycle.
  - Reset overrides a simultaneous accept.
  - Reset mid-shift or in DONE discards the operation; no valid_o is produced for it.
- Latency, counted from the accept edge to the first cycle with valid_o = 1:
  - 1 cycle for non-shift ops and shamt = 0.
  - 1 + ceil(shamt / SHIFT_STEP) − 1 = ceil(shamt / SHIFT_STEP) edges after accept for shamt > 0, i.e. valid_o rises in the cycle after the final SHIFT edge.
- Throughput: one non-shift op per cycle while ready_i stays high.
- While in SHIFT: ready_o = 0 and valid_o = 0.
- Back-pressure: ready_i low in DONE holds the result indefinitely, and ready_o = 0.
- Worst case (WIDTH=32, SHIFT_STEP=1, shamt=31): 31 cycles in SHIFT.

## Test plan
- Reset, then ADD 0x7FFF_FFFF + 0x0000_0001 with ready_i=1: valid_o in the next cycle, result 0x8000_0000. SUB 0 − 1 (funct7=0x20) gives 0xFFFF_FFFF.
- SLT 0xFFFF_FFFF vs 0x0000_0001 gives 1; SLTU on the same operands gives 0. XOR/OR/AND of 0xF0F0_F0F0 with 0xFF00_FF00 give 0x0FF0_0FF0, 0xFFF0_FFF0 and 0xF000_F000.
- Shifts (WIDTH=32, SHIFT_STEP=1):
  - SRA 0x8000_0000 by 4 gives 0xF800_0000, with ready_o low for exactly 4 cycles after accept.
  - SLL 0x1 by operand_2=0x0000_0021 (shamt 1) gives 0x2.
  - SRL by 0 gives valid_o after 1 cycle.
- Repeat with SHIFT_STEP=8: SRL 0xFFFF_FFFF by 31 gives 0x0000_0001, with valid_o 4 edges after accept.
- Back-pressure: hold ready_i=0 for 5 cycles in DONE. result_o and valid_o must stay stable and ready_o = 0. Raising ready_i together with valid_i on a new ADD gives back-to-back valid_o with no idle cycle.
- Assert rst_i mid-shift (SLL by 20): valid_o stays 0 and result_o = 0 next cycle. A following ADD 2+3 gives 5 with 1-cycle latency.
